// File: rtl/alu_scheduler.sv
// rtl/alu_scheduler.sv - round-robin sharing of one alu between two valid/ready requesters
// Comb ops respond two cycles after accept; sel=111 pulses alu reset and waits SEQ_CYCLES first.
module alu_scheduler #(
   parameter int WIDTH      = 32,
   parameter int SEQ_CYCLES = 64,
   parameter int CNT_W      = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_req0_valid,
   output logic             o_req0_ready,
   input  logic [WIDTH-1:0] i_req0_a,
   input  logic [WIDTH-1:0] i_req0_b,
   input  logic [2:0]       i_req0_sel,
   input  logic             i_req1_valid,
   output logic             o_req1_ready,
   input  logic [WIDTH-1:0] i_req1_a,
   input  logic [WIDTH-1:0] i_req1_b,
   input  logic [2:0]       i_req1_sel,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_id,
   output logic [WIDTH-1:0] o_rsp_res,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   output logic [2:0]       o_alu_sel,
   output logic             o_alu_reset,
   input  logic [WIDTH-1:0] i_alu_res,
   output logic             o_busy
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_COMB,
      S_SEQ_RST,
      S_SEQ_WAIT,
      S_RESP
   } state_t;

   localparam logic [2:0]       SEL_SEQ  = 3'b111;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic             r_last_grant;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rsp_valid;
   logic             r_rsp_id;
   logic [WIDTH-1:0] r_rsp_res;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_sel;

   logic             w_grant;
   logic             w_accept;
   logic             w_cnt_done;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [2:0]       w_sel;

   // A tie goes to whoever was not served last; a lone requester always wins.
   assign w_grant    = (i_req0_valid & i_req1_valid) ? ~r_last_grant : i_req1_valid;
   assign w_a        = w_grant ? i_req1_a   : i_req0_a;
   assign w_b        = w_grant ? i_req1_b   : i_req0_b;
   assign w_sel      = w_grant ? i_req1_sel : i_req0_sel;
   assign w_cnt_done = (r_cnt == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_accept     = 1'b0;
      o_req0_ready = 1'b0;
      o_req1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!i_reset && (i_req0_valid || i_req1_valid)) begin
               w_accept     = 1'b1;
               o_req0_ready = ~w_grant;
               o_req1_ready = w_grant;
               w_next       = (w_sel == SEL_SEQ) ? S_SEQ_RST : S_COMB;
            end
         end
         S_COMB:     w_next = S_RESP;
         S_SEQ_RST:  w_next = S_SEQ_WAIT;
         S_SEQ_WAIT: if (w_cnt_done) w_next = S_RESP;
         S_RESP:     if (i_rsp_ready) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= 1'b0;
         r_rsp_res    <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_sel    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_alu_a   <= w_a;
                  r_alu_b   <= w_b;
                  r_alu_sel <= w_sel;
                  r_rsp_id  <= w_grant;
               end
            end
            S_COMB: begin
               r_rsp_res   <= i_alu_res;
               r_rsp_valid <= 1'b1;
            end
            S_SEQ_RST: r_cnt <= '0;
            S_SEQ_WAIT: begin
               // Hold at the terminal count so the counter never wraps.
               if (w_cnt_done) begin
                  r_rsp_res   <= i_alu_res;
                  r_rsp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RESP: begin
               if (i_rsp_ready) begin
                  r_rsp_valid  <= 1'b0;
                  r_last_grant <= r_rsp_id;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_alu_reset = i_reset | (r_state == S_SEQ_RST);
   assign o_busy      = (r_state != S_IDLE);
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_id    = r_rsp_id;
   assign o_rsp_res   = r_rsp_res;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_sel   = r_alu_sel;

endmodule

// File: tb/tb_alu_scheduler.sv
// tb/tb_alu_scheduler.sv - self-checking bench for alu_scheduler with an alu stub
// Directed scenarios plus a randomized run against a transaction-level reference model.
module tb_alu_scheduler;
   localparam int W   = 32;
   localparam int SEQ = 64;

   logic          clk;
   logic          reset;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
   logic [2:0]    req0_sel, req1_sel;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [W-1:0]  rsp_res;
   logic [W-1:0]  alu_a, alu_b, alu_res;
   logic [2:0]    alu_sel;
   logic          alu_reset;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0]  op_a [2][8];
   logic [W-1:0]  op_b [2][8];
   logic [2:0]    op_s [2][8];
   int            grant_q[$];
   logic          rid_q[$];
   logic [W-1:0]  rres_q[$];
   int            rdy_cnt[2];

   alu_scheduler #(.WIDTH(W), .SEQ_CYCLES(SEQ), .CNT_W(8)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_req0_valid(req0_valid), .o_req0_ready(req0_ready),
      .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req0_sel(req0_sel),
      .i_req1_valid(req1_valid), .o_req1_ready(req1_ready),
      .i_req1_a(req1_a), .i_req1_b(req1_b), .i_req1_sel(req1_sel),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id), .o_rsp_res(rsp_res),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel), .o_alu_reset(alu_reset),
      .i_alu_res(alu_res), .o_busy(busy)
   );

   function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] s);
      case (s)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return a << b[4:0];
         3'd6:    return a * b;
         default: return (b == 0) ? '0 : a % b;
      endcase
   endfunction

   // Alu stub: sel 111 only gives a correct result SEQ cycles after its reset.
   int stub_cnt = 0;
   always @(posedge clk) begin
      if (alu_reset) stub_cnt <= 0;
      else if (stub_cnt < 100000) stub_cnt <= stub_cnt + 1;
   end
   always_comb begin
      alu_res = ref_alu(alu_a, alu_b, alu_sel);
      if (alu_sel == 3'b111 && stub_cnt < SEQ - 1) alu_res = 32'hBAD0_BAD0;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0;
      req0_a = '0; req0_b = '0; req0_sel = '0;
      req1_a = '0; req1_b = '0; req1_sel = '0;
   endtask

   task automatic do_reset();
      @(negedge clk); reset = 1; idle_inputs();
      @(negedge clk); reset = 0;
   endtask

   // Holds each requester valid while it still has ops queued; records grants and responses.
   task automatic drive_both(input int n0, input int n1);
      int k0 = 0, k1 = 0, got = 0, guard = 0;
      grant_q.delete(); rid_q.delete(); rres_q.delete();
      rdy_cnt[0] = 0; rdy_cnt[1] = 0;
      rsp_ready = 1;
      while (got < n0 + n1 && guard < 2000) begin
         @(negedge clk);
         req0_valid = (k0 < n0);
         req1_valid = (k1 < n1);
         if (k0 < n0) begin req0_a = op_a[0][k0]; req0_b = op_b[0][k0]; req0_sel = op_s[0][k0]; end
         if (k1 < n1) begin req1_a = op_a[1][k1]; req1_b = op_b[1][k1]; req1_sel = op_s[1][k1]; end
         #1;
         if (req0_ready) rdy_cnt[0]++;
         if (req1_ready) rdy_cnt[1]++;
         if (req0_valid && req0_ready) begin grant_q.push_back(0); k0++; end
         if (req1_valid && req1_ready) begin grant_q.push_back(1); k1++; end
         if (rsp_valid && rsp_ready) begin rid_q.push_back(rsp_id); rres_q.push_back(rsp_res); got++; end
         guard++;
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      @(negedge clk); reset = 1; idle_inputs(); rsp_ready = 0;
      @(negedge clk); #1;
      n_checks++; if (alu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_alu_reset got=%0b exp=1", alu_reset); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%0b exp=0", rsp_valid); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_id got=%0b exp=0", rsp_id); end
      n_checks++; if (rsp_res !== '0) begin n_fail++; $display("FAIL rst_rsp_res got=%0h exp=0", rsp_res); end
      n_checks++; if ({alu_a, alu_b, alu_sel} !== '0) begin n_fail++; $display("FAIL rst_alu_ops got=%0h/%0h/%0d exp=0", alu_a, alu_b, alu_sel); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      @(negedge clk); reset = 0; #1;
      n_checks++; if (alu_reset !== 1'b0) begin n_fail++; $display("FAIL rst_release_alu_reset got=%0b exp=0", alu_reset); end
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready_no_valid got=%0b exp=00", {req0_ready, req1_ready}); end
   endtask

   task automatic test_comb();
      do_reset(); rsp_ready = 1;
      @(negedge clk); req0_valid = 1; req0_a = 8; req0_b = 4; req0_sel = 3'b000; #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL t1_ready got=%0b exp=10", {req0_ready, req1_ready}); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_c0 got=%0b exp=0", busy); end
      @(negedge clk); req0_valid = 0; #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_c1 got=%0b exp=1", busy); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rsp_valid_c1 got=%0b exp=0", rsp_valid); end
      n_checks++; if ({alu_a, alu_b} !== {32'd8, 32'd4}) begin n_fail++; $display("FAIL t1_alu_ops got=%0d/%0d exp=8/4", alu_a, alu_b); end
      @(negedge clk); #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t1_rsp_valid_c2 got=%0b exp=1", rsp_valid); end
      n_checks++; if (rsp_res !== 32'd12) begin n_fail++; $display("FAIL t1_res got=%0d exp=12", rsp_res); end
      n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL t1_id got=%0b exp=0", rsp_id); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_c2 got=%0b exp=1", busy); end
      @(negedge clk); #1;
      n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL t1_done got=%0b exp=00", {rsp_valid, busy}); end
   endtask

   task automatic check_grants(input string tag, input int n);
      int m[2];
      int id;
      m[0] = 0; m[1] = 0;
      n_checks++; if (grant_q.size() != n) begin n_fail++; $display("FAIL %s_grant_count got=%0d exp=%0d", tag, grant_q.size(), n); end
      n_checks++; if (rid_q.size() != n) begin n_fail++; $display("FAIL %s_rsp_count got=%0d exp=%0d", tag, rid_q.size(), n); end
      for (int j = 0; j < n && j < grant_q.size() && j < rid_q.size(); j++) begin
         id = grant_q[j];
         n_checks++; if (id != (j % 2)) begin n_fail++; $display("FAIL %s_grant_order[%0d] got=%0d exp=%0d", tag, j, id, j % 2); end
         n_checks++; if (rid_q[j] !== id[0]) begin n_fail++; $display("FAIL %s_rsp_id[%0d] got=%0b exp=%0d", tag, j, rid_q[j], id); end
         n_checks++;
         if (rres_q[j] !== ref_alu(op_a[id][m[id]], op_b[id][m[id]], op_s[id][m[id]])) begin
            n_fail++; $display("FAIL %s_rsp_res[%0d] got=%0h exp=%0h", tag, j, rres_q[j],
                               ref_alu(op_a[id][m[id]], op_b[id][m[id]], op_s[id][m[id]]));
         end
         m[id]++;
      end
   endtask

   task automatic test_tie();
      do_reset();
      op_a[0][0] = 8;  op_b[0][0] = 4; op_s[0][0] = 3'd0;
      op_a[1][0] = 20; op_b[1][0] = 7; op_s[1][0] = 3'd1;
      drive_both(1, 1);
      check_grants("t2", 2);
      n_checks++; if (rdy_cnt[0] != 1 || rdy_cnt[1] != 1) begin n_fail++; $display("FAIL t2_ready_pulses got=%0d/%0d exp=1/1", rdy_cnt[0], rdy_cnt[1]); end
   endtask

   task automatic test_seq();
      int n_rst = 0, rst_t = -1, first = -1;
      logic [W-1:0] res = '0;
      logic id = 1'b0;
      do_reset(); rsp_ready = 1;
      @(negedge clk); req1_valid = 1; req1_a = 14; req1_b = 5; req1_sel = 3'b111; #1;
      n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL t3_ready got=%0b exp=01", {req0_ready, req1_ready}); end
      for (int t = 1; t <= SEQ + 3; t++) begin
         @(negedge clk); req1_valid = 0; #1;
         if (alu_reset) begin n_rst++; rst_t = t; end
         if (rsp_valid && first < 0) begin first = t; res = rsp_res; id = rsp_id; end
      end
      n_checks++; if (n_rst != 1 || rst_t != 1) begin n_fail++; $display("FAIL t3_alu_reset_pulse got=%0d@%0d exp=1@1", n_rst, rst_t); end
      n_checks++; if (first != SEQ + 2) begin n_fail++; $display("FAIL t3_latency got=%0d exp=%0d", first, SEQ + 2); end
      n_checks++; if (res !== 32'd4) begin n_fail++; $display("FAIL t3_res got=%0d exp=4", res); end
      n_checks++; if (id !== 1'b1) begin n_fail++; $display("FAIL t3_id got=%0b exp=1", id); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] exp_res;
      int waited = 0;
      do_reset(); rsp_ready = 0;
      @(negedge clk); req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_sel = 3'($urandom_range(0, 6));
      exp_res = ref_alu(req0_a, req0_b, req0_sel);
      @(negedge clk); req0_valid = 0; #1;
      while (!rsp_valid && waited < 10) begin @(negedge clk); #1; waited++; end
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t4_rsp_arrive got=%0b exp=1", rsp_valid); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_sel = 3'($urandom_range(0, 7));
         req1_valid = 1; req1_a = $urandom; req1_b = $urandom; req1_sel = 3'($urandom_range(0, 7));
         #1;
         n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t4_hold_valid[%0d] got=%0b exp=1", i, rsp_valid); end
         n_checks++; if (rsp_res !== exp_res) begin n_fail++; $display("FAIL t4_hold_res[%0d] got=%0h exp=%0h", i, rsp_res, exp_res); end
         n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL t4_hold_id[%0d] got=%0b exp=0", i, rsp_id); end
         n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL t4_ready_blocked[%0d] got=%0b exp=00", i, {req0_ready, req1_ready}); end
      end
      @(negedge clk); idle_inputs(); rsp_ready = 1; #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL t4_release_valid got=%0b exp=1", rsp_valid); end
      @(negedge clk); rsp_ready = 0; #1;
      n_checks++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL t4_completed got=%0b exp=00", {rsp_valid, busy}); end
   endtask

   task automatic test_reset_mid_seq();
      int n_rsp = 0;
      logic [W-1:0] exp_res;
      do_reset(); rsp_ready = 1;
      @(negedge clk); req0_valid = 1; req0_a = 100; req0_b = 7; req0_sel = 3'b111;
      for (int i = 0; i < 20; i++) begin @(negedge clk); req0_valid = 0; end
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy_wait got=%0b exp=1", busy); end
      @(negedge clk); reset = 1; #1;
      n_checks++; if (alu_reset !== 1'b1) begin n_fail++; $display("FAIL t5_alu_reset got=%0b exp=1", alu_reset); end
      @(negedge clk); reset = 0; #1;
      n_checks++; if ({rsp_valid, busy, alu_reset} !== 3'b000) begin n_fail++; $display("FAIL t5_after_reset got=%0b exp=000", {rsp_valid, busy, alu_reset}); end
      n_checks++; if ({alu_a, alu_b, alu_sel} !== '0) begin n_fail++; $display("FAIL t5_alu_ops got=%0h/%0h/%0d exp=0", alu_a, alu_b, alu_sel); end
      for (int i = 0; i < SEQ + 5; i++) begin @(negedge clk); #1; if (rsp_valid) n_rsp++; end
      n_checks++; if (n_rsp != 0) begin n_fail++; $display("FAIL t5_no_response got=%0d exp=0", n_rsp); end
      @(negedge clk); req0_valid = 1; req0_a = $urandom; req0_b = $urandom; req0_sel = 3'b000; #1;
      exp_res = req0_a + req0_b;
      n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL t5_fresh_ready got=%0b exp=1", req0_ready); end
      @(negedge clk); req0_valid = 0;
      @(negedge clk); #1;
      n_checks++; if ({rsp_valid, rsp_id} !== 2'b10 || rsp_res !== exp_res) begin
         n_fail++; $display("FAIL t5_fresh_rsp got=v%0b id%0b %0h exp=v1 id0 %0h", rsp_valid, rsp_id, rsp_res, exp_res);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 3; k++) begin
            op_a[r][k] = $urandom; op_b[r][k] = $urandom; op_s[r][k] = 3'($urandom_range(0, 6));
         end
      end
      drive_both(3, 3);
      check_grants("t6", 6);
   endtask

   // Reference: one op in flight; tie goes to the requester not served last.
   task automatic test_random();
      bit inflight = 0;
      int due = 0, last = 1, n_done = 0;
      logic exp_id = 1'b0;
      logic [W-1:0] exp_res = '0;
      bit r0, r1, exp_rv;
      do_reset();
      for (int t = 0; t < 800; t++) begin
         @(negedge clk);
         req0_valid = ($urandom_range(0, 99) < 60);
         req1_valid = ($urandom_range(0, 99) < 60);
         req0_a = $urandom; req0_b = $urandom | 32'd1; req0_sel = 3'($urandom_range(0, 7));
         req1_a = $urandom; req1_b = $urandom | 32'd1; req1_sel = 3'($urandom_range(0, 7));
         rsp_ready = ($urandom_range(0, 1) == 1);
         #1;
         r0 = !inflight && req0_valid && (!req1_valid || last == 1);
         r1 = !inflight && req1_valid && (!req0_valid || last == 0);
         exp_rv = inflight && (t >= due);
         n_checks++; if ({req0_ready, req1_ready} !== {r0, r1}) begin n_fail++; $display("FAIL rnd_ready t=%0d got=%0b exp=%0b", t, {req0_ready, req1_ready}, {r0, r1}); end
         n_checks++; if (busy !== inflight) begin n_fail++; $display("FAIL rnd_busy t=%0d got=%0b exp=%0b", t, busy, inflight); end
         n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_rsp_valid t=%0d got=%0b exp=%0b", t, rsp_valid, exp_rv); end
         if (exp_rv) begin
            n_checks++; if (rsp_id !== exp_id || rsp_res !== exp_res) begin
               n_fail++; $display("FAIL rnd_rsp t=%0d got=id%0b %0h exp=id%0b %0h", t, rsp_id, rsp_res, exp_id, exp_res);
            end
         end
         if (exp_rv && rsp_ready) begin
            inflight = 0; last = int'(exp_id); n_done++;
         end else if (r0 || r1) begin
            inflight = 1;
            exp_id   = r1;
            exp_res  = r1 ? ref_alu(req1_a, req1_b, req1_sel) : ref_alu(req0_a, req0_b, req0_sel);
            due      = t + (((r1 ? req1_sel : req0_sel) == 3'b111) ? SEQ + 2 : 2);
         end
      end
      idle_inputs(); rsp_ready = 0;
      n_checks++; if (n_done < 10) begin n_fail++; $display("FAIL rnd_throughput got=%0d exp>=10", n_done); end
   endtask

   initial begin
      reset = 1; rsp_ready = 0; idle_inputs();
      test_reset();
      test_comb();
      test_tie();
      test_seq();
      test_backpressure();
      test_reset_mid_seq();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
